// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: one request/acknowledge pair plus address and returned word.
interface if_stage_if;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ack;
    logic [31:0] mem_if_data;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  mem_if_ack,
        input  mem_if_data
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output mem_if_ack,
        output mem_if_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch outstanding,
// and feeds the IF/ID register through a one-entry skid buffer.
//
// state | meaning
// FETCH | request at PC outstanding; ack loads IF/ID or the skid buffer
// HOLD  | skid buffer full behind a stalled IF/ID; no request issued
// DROP  | redirected while a fetch was in flight; wait for its ack and discard it
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ex_take_branch,
    input  logic [31:0] i_ex_target_PC,
    input  logic        i_id_stall,
    if_stage_if.master  mem,
    output logic [31:0] o_if_id_PC,
    output logic [31:0] o_if_id_NPC,
    output logic [31:0] o_if_id_IR,
    output logic        o_if_id_valid_inst
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_pc,       w_pc_nxt;
    logic [31:0] r_req_addr, w_req_addr_nxt;
    logic [31:0] r_skid_pc,  w_skid_pc_nxt;
    logic [31:0] r_skid_ir,  w_skid_ir_nxt;
    logic [31:0] r_id_pc,    w_id_pc_nxt;
    logic [31:0] r_id_npc,   w_id_npc_nxt;
    logic [31:0] r_id_ir,    w_id_ir_nxt;
    logic        r_id_valid, w_id_valid_nxt;

    logic        w_req;
    logic        w_ack;
    logic        w_id_free;
    logic [31:0] w_pc_plus4;

    // A request is live in FETCH and DROP; reset suppresses it so a pending fetch is abandoned.
    assign w_req      = (r_state != S_HOLD) && !i_rst;
    assign w_ack      = mem.mem_if_ack && w_req;
    assign w_id_free  = !r_id_valid || !i_id_stall;
    assign w_pc_plus4 = r_pc + 32'd4;

    // In DROP the stale request must keep its original address until it completes.
    assign mem.if_mem_req  = w_req;
    assign mem.if_mem_addr = (r_state == S_DROP) ? r_req_addr : r_pc;

    assign o_if_id_PC         = r_id_pc;
    assign o_if_id_NPC        = r_id_npc;
    assign o_if_id_IR         = r_id_ir;
    assign o_if_id_valid_inst = r_id_valid;

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_skid_pc  <= 32'd0;
            r_skid_ir  <= NOP_INST;
            r_id_pc    <= 32'd0;
            r_id_npc   <= 32'd0;
            r_id_ir    <= NOP_INST;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_skid_pc  <= w_skid_pc_nxt;
            r_skid_ir  <= w_skid_ir_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_npc   <= w_id_npc_nxt;
            r_id_ir    <= w_id_ir_nxt;
            r_id_valid <= w_id_valid_nxt;
        end
    end

    // Next-state, PC, skid and IF/ID update; a redirect overrides ack, stall and skid.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_skid_pc_nxt  = r_skid_pc;
        w_skid_ir_nxt  = r_skid_ir;
        w_id_pc_nxt    = r_id_pc;
        w_id_npc_nxt   = r_id_npc;
        w_id_ir_nxt    = r_id_ir;
        w_id_valid_nxt = r_id_valid;

        if (r_state == S_FETCH) begin
            w_req_addr_nxt = r_pc;
        end

        if (i_ex_take_branch) begin
            w_pc_nxt       = i_ex_target_PC & 32'hFFFF_FFFC;
            w_id_valid_nxt = 1'b0;
            w_id_ir_nxt    = NOP_INST;
            w_skid_pc_nxt  = 32'd0;
            w_skid_ir_nxt  = NOP_INST;
            case (r_state)
                S_FETCH: w_state_nxt = w_ack ? S_FETCH : S_DROP;
                S_HOLD:  w_state_nxt = S_FETCH;
                S_DROP:  w_state_nxt = w_ack ? S_FETCH : S_DROP;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_pc_nxt = w_pc_plus4;
                        if (w_id_free) begin
                            w_id_pc_nxt    = r_pc;
                            w_id_npc_nxt   = w_pc_plus4;
                            w_id_ir_nxt    = mem.mem_if_data;
                            w_id_valid_nxt = 1'b1;
                        end else begin
                            w_skid_pc_nxt = r_pc;
                            w_skid_ir_nxt = mem.mem_if_data;
                            w_state_nxt   = S_HOLD;
                        end
                    end else if (!i_id_stall) begin
                        w_id_valid_nxt = 1'b0;
                        w_id_ir_nxt    = NOP_INST;
                    end
                end
                S_HOLD: begin
                    if (!i_id_stall) begin
                        w_id_pc_nxt    = r_skid_pc;
                        w_id_npc_nxt   = r_skid_pc + 32'd4;
                        w_id_ir_nxt    = r_skid_ir;
                        w_id_valid_nxt = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        w_state_nxt = S_FETCH;
                    end
                    if (!i_id_stall) begin
                        w_id_valid_nxt = 1'b0;
                        w_id_ir_nxt    = NOP_INST;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model answers with its own address as the
// instruction word after a programmable number of wait cycles.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] id_pc, id_npc, id_ir;
    logic        id_valid;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int cnt = 0;

    if_stage_if mem_bus ();

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ex_take_branch   (br),
        .i_ex_target_PC     (tgt),
        .i_id_stall         (stall),
        .mem                (mem_bus),
        .o_if_id_PC         (id_pc),
        .o_if_id_NPC        (id_npc),
        .o_if_id_IR         (id_ir),
        .o_if_id_valid_inst (id_valid)
    );

    always #5 clk = ~clk;

    // Memory: ack once the request has waited lat cycles; data mirrors the address.
    always_comb begin
        mem_bus.mem_if_ack  = mem_bus.if_mem_req && (cnt >= lat);
        mem_bus.mem_if_data = mem_bus.if_mem_addr;
    end

    always @(posedge clk) begin
        if (mem_bus.if_mem_req && !mem_bus.mem_if_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic do_reset();
        rst = 1'b1; br = 1'b0; stall = 1'b0; lat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; br = 1'b0; stall = 1'b0; lat = 0;
        repeat (2) @(negedge clk);
        checks++; if (mem_bus.if_mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_bus.if_mem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if (id_ir !== NOP) begin errors++; $display("FAIL rst_ir: got %h want %h", id_ir, NOP); end
        checks++; if (id_pc !== 32'd0 || id_npc !== 32'd0) begin errors++; $display("FAIL rst_pc_npc: got %h/%h want 0/0", id_pc, id_npc); end
        checks++; if (mem_bus.if_mem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_bus.if_mem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (mem_bus.if_mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", mem_bus.if_mem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_zero_latency();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL zl_valid[%0d]: got %b want 1", i, id_valid); end
            checks++; if (id_pc !== 32'(4*i) || id_ir !== 32'(4*i)) begin errors++; $display("FAIL zl_pc_ir[%0d]: got %h/%h want %h", i, id_pc, id_ir, 32'(4*i)); end
            checks++; if (id_npc !== 32'(4*i+4)) begin errors++; $display("FAIL zl_npc[%0d]: got %h want %h", i, id_npc, 32'(4*i+4)); end
        end
    endtask

    task automatic test_latency3();
        lat = 3;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 4; c++) begin
                checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'(16+4*f))
                    begin errors++; $display("FAIL l3_addr[%0d.%0d]: got req=%b addr=%h want 1/%h", f, c, mem_bus.if_mem_req, mem_bus.if_mem_addr, 32'(16+4*f)); end
                if (c > 0) begin
                    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL l3_bubble[%0d.%0d]: got %b want 0", f, c, id_valid); end
                end
                @(negedge clk);
            end
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(16+4*f) || id_ir !== 32'(16+4*f))
                begin errors++; $display("FAIL l3_load[%0d]: got v=%b pc=%h ir=%h want pc=%h", f, id_valid, id_pc, id_ir, 32'(16+4*f)); end
        end
        lat = 0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        repeat (3) @(negedge clk);
        checks++; if (id_pc !== 32'd8 || id_valid !== 1'b1) begin errors++; $display("FAIL st_pre: got pc=%h v=%b want 8/1", id_pc, id_valid); end
        stall = 1'b1;
        #1;
        checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'd12) begin errors++; $display("FAIL st_inflight: got req=%b addr=%h want 1/c", mem_bus.if_mem_req, mem_bus.if_mem_addr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (id_pc !== 32'd8 || id_npc !== 32'd12 || id_ir !== 32'd8 || id_valid !== 1'b1)
                begin errors++; $display("FAIL st_hold[%0d]: got pc=%h npc=%h ir=%h v=%b want 8/c/8/1", k, id_pc, id_npc, id_ir, id_valid); end
            checks++; if (mem_bus.if_mem_req !== 1'b0) begin errors++; $display("FAIL st_req_low[%0d]: got %b want 0", k, mem_bus.if_mem_req); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (id_pc !== 32'd12 || id_ir !== 32'd12 || id_valid !== 1'b1) begin errors++; $display("FAIL st_skid_out: got pc=%h ir=%h v=%b want c/c/1", id_pc, id_ir, id_valid); end
        checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'd16) begin errors++; $display("FAIL st_resume: got req=%b addr=%h want 1/10", mem_bus.if_mem_req, mem_bus.if_mem_addr); end
        @(negedge clk);
        checks++; if (id_pc !== 32'd16 || id_valid !== 1'b1) begin errors++; $display("FAIL st_next: got pc=%h v=%b want 10/1", id_pc, id_valid); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        repeat (8) @(negedge clk);
        checks++; if (mem_bus.if_mem_addr !== 32'h20) begin errors++; $display("FAIL dr_pre_addr: got %h want 20", mem_bus.if_mem_addr); end
        lat = 3;
        @(negedge clk);
        br = 1'b1; tgt = 32'h0000_0103;
        @(negedge clk);
        br = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'h20) begin errors++; $display("FAIL dr_stale[%0d]: got req=%b addr=%h want 1/20", k, mem_bus.if_mem_req, mem_bus.if_mem_addr); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL dr_valid_stale[%0d]: got %b want 0", k, id_valid); end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'h100) begin errors++; $display("FAIL dr_new[%0d]: got req=%b addr=%h want 1/100", k, mem_bus.if_mem_req, mem_bus.if_mem_addr); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL dr_valid_new[%0d]: got %b want 0", k, id_valid); end
            @(negedge clk);
        end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_ir !== 32'h100) begin errors++; $display("FAIL dr_land: got v=%b pc=%h ir=%h want 1/100/100", id_valid, id_pc, id_ir); end
        lat = 0;
    endtask

    task automatic test_redirect_ack_stall();
        do_reset();
        @(negedge clk);
        checks++; if (id_pc !== 32'd0 || id_valid !== 1'b1) begin errors++; $display("FAIL ra_pre: got pc=%h v=%b want 0/1", id_pc, id_valid); end
        stall = 1'b1; br = 1'b1; tgt = 32'h0000_0042;
        @(negedge clk);
        br = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_ir !== NOP) begin errors++; $display("FAIL ra_squash: got v=%b ir=%h want 0/%h", id_valid, id_ir, NOP); end
        checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'h40) begin errors++; $display("FAIL ra_addr: got req=%b addr=%h want 1/40", mem_bus.if_mem_req, mem_bus.if_mem_addr); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_ir !== 32'h40) begin errors++; $display("FAIL ra_land: got v=%b pc=%h ir=%h want 1/40/40", id_valid, id_pc, id_ir); end
        stall = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        br = 1'b1; tgt = 32'hFFFF_FFFC;
        @(negedge clk);
        br = 1'b0;
        checks++; if (mem_bus.if_mem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin errors++; $display("FAIL wr_addr: got addr=%h v=%b want fffffffc/0", mem_bus.if_mem_addr, id_valid); end
        @(negedge clk);
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_npc !== 32'd0 || id_ir !== 32'hFFFF_FFFC || id_valid !== 1'b1)
            begin errors++; $display("FAIL wr_ifid: got pc=%h npc=%h ir=%h v=%b want fffffffc/0/fffffffc/1", id_pc, id_npc, id_ir, id_valid); end
        checks++; if (mem_bus.if_mem_addr !== 32'd0) begin errors++; $display("FAIL wr_next_addr: got %h want 0", mem_bus.if_mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (id_pc !== 32'd4 || mem_bus.if_mem_addr !== 32'd8) begin errors++; $display("FAIL wr_post: got pc=%h addr=%h want 4/8", id_pc, mem_bus.if_mem_addr); end
        lat = 3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mem_bus.if_mem_req !== 1'b0) begin errors++; $display("FAIL mr_req: got %b want 0", mem_bus.if_mem_req); end
        @(negedge clk);
        checks++; if (id_pc !== 32'd0 || id_npc !== 32'd0 || id_valid !== 1'b0 || id_ir !== NOP)
            begin errors++; $display("FAIL mr_ifid: got pc=%h npc=%h v=%b ir=%h want 0/0/0/%h", id_pc, id_npc, id_valid, id_ir, NOP); end
        rst = 1'b0; lat = 0;
        #1;
        checks++; if (mem_bus.if_mem_req !== 1'b1 || mem_bus.if_mem_addr !== 32'd0) begin errors++; $display("FAIL mr_req_addr: got req=%b addr=%h want 1/0", mem_bus.if_mem_req, mem_bus.if_mem_addr); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_ir !== 32'd0) begin errors++; $display("FAIL mr_first: got v=%b pc=%h ir=%h want 1/0/0", id_valid, id_pc, id_ir); end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_latency3();
        test_stall_skid();
        test_redirect_drop();
        test_redirect_ack_stall();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
